// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy encoding and default widths.
package pipe_pkg;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_CTRL_W = 16;

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid bit plus payload and control, with load and clear.
// Clearing zeroes the payload so an invalid entry always reads as a bubble.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) pipeline stage with registered in_ready and bubble-zeroed outputs.
// Define PIPE_STAGE_SKID_PERF_EN to add the saturating stall_cnt counter and port.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
`ifdef PIPE_STAGE_SKID_PERF_EN
    output logic [31:0]       stall_cnt,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data, main_ld_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ld_ctrl;
    logic              main_load, main_clear, skid_load, skid_clear, main_from_skid;
    logic              accept, xfer;
    occ_e              state;

    // in_ready depends only on the skid register, never on out_ready.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : '0;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;

    always_comb begin
        state = OccEmpty;
        if (main_valid) begin
            state = skid_valid ? OccFull : OccOne;
        end
    end

    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                OccEmpty: begin
                    main_load = accept;
                end
                OccOne: begin
                    if (accept && !xfer) begin
                        skid_load = 1'b1;
                    end else if (accept && xfer) begin
                        main_load = 1'b1;
                    end else if (xfer) begin
                        main_clear = 1'b1;
                    end
                end
                OccFull: begin
                    if (xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_ld_data = main_from_skid ? skid_data : in_data;
    assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .clear     (main_clear),
        .load      (main_load),
        .load_data (main_ld_data),
        .load_ctrl (main_ld_ctrl),
        .valid     (main_valid),
        .data      (main_data),
        .ctrl      (main_ctrl)
    );

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (skid_clear),
        .load      (skid_load),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
    );

`ifdef PIPE_STAGE_SKID_PERF_EN
    // Flush deliberately does not touch the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: FIFO-of-two reference model plus directed literals.
module tb_pipe_stage_skid;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [31:0]       stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
`ifdef PIPE_STAGE_SKID_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage behaves as an ordered queue of at most two entries.
    logic [DATA_W-1:0] q_data[$];
    logic [CTRL_W-1:0] q_ctrl[$];
    logic [31:0]       stall_m = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q_data.delete();
            q_ctrl.delete();
            stall_m = '0;
        end else begin
            automatic bit acc = in_valid && (q_data.size() < 2);
            automatic bit xf  = (q_data.size() > 0) && out_ready;
            if (q_data.size() > 0 && !out_ready && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
            if (flush) begin
                q_data.delete();
                q_ctrl.delete();
            end else begin
                if (xf) begin
                    void'(q_data.pop_front());
                    void'(q_ctrl.pop_front());
                end
                if (acc) begin
                    q_data.push_back(in_data);
                    q_ctrl.push_back(in_ctrl);
                end
            end
        end
    end

    always @(negedge clk) begin
        automatic bit m_valid = q_data.size() > 0;
        chk("cmp_out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        chk("cmp_in_ready", {63'd0, in_ready}, {63'd0, q_data.size() < 2});
        chk("cmp_out_data", out_data, m_valid ? q_data[0] : '0);
        chk("cmp_out_ctrl", {48'd0, out_ctrl}, m_valid ? {48'd0, q_ctrl[0]} : 64'd0);
`ifdef PIPE_STAGE_SKID_PERF_EN
        chk("cmp_stall_cnt", {32'd0, stall_cnt}, {32'd0, stall_m});
`endif
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_data", out_data, 64'd0);
        cycle();
        reset = 1'b0;
        cycle();

        // Streaming with no backpressure: latency one, in_ready stays high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 64'(i);
            in_ctrl = 16'(i + 100);
            cycle();
            chk("stream_data", out_data, 64'(i));
            chk("stream_ctrl", {48'd0, out_ctrl}, 64'(i + 100));
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        in_data  = 64'hDEAD;
        cycle();
        chk("stream_bubble_valid", {63'd0, out_valid}, 64'd0);
        chk("stream_bubble_data", out_data, 64'd0);

        // Backpressure fills the skid; order is kept when released.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        in_ctrl   = 16'h1A;
        cycle();
        chk("bp_first", out_data, 64'hA);
        chk("bp_ready_one", {63'd0, in_ready}, 64'd1);
        in_data = 64'hB;
        in_ctrl = 16'h1B;
        cycle();
        chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_full_head", out_data, 64'hA);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("bp_second", out_data, 64'hB);
        chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
        cycle();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // Flush while full, with a colliding accept that must be dropped.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h11;
        cycle();
        in_data = 64'h12;
        cycle();
        in_data = 64'hC;
        in_ctrl = 16'hCC;
        flush   = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ctrl", {48'd0, out_ctrl}, 64'd0);
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        cycle();
        chk("flush_no_c", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset in ONE, then first accept lands in main.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h55;
        cycle();
        in_valid = 1'b0;
        chk("areset_pre", {63'd0, out_valid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid", {63'd0, out_valid}, 64'd0);
        chk("areset_ready", {63'd0, in_ready}, 64'd1);
        cycle();
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'h77;
        cycle();
        in_valid = 1'b0;
        chk("areset_first", out_data, 64'h77);

`ifdef PIPE_STAGE_SKID_PERF_EN
        // Counter: one stalled entry for five edges, then a flush during a transfer.
        reset = 1'b1;
        cycle();
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'h5;
        cycle();
        in_valid = 1'b0;
        repeat (5) cycle();
        chk("perf_five", {32'd0, stall_cnt}, 64'd5);
        flush     = 1'b1;
        out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        chk("perf_after_flush", {32'd0, stall_cnt}, 64'd5);
`endif

        // Random traffic; the compare process checks every cycle against the model.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 63) == 0;
            in_data   = {$urandom, $urandom};
            in_ctrl   = 16'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL take parameter DATA_W, default 64, payload width (e.g. PC+4 and IR).
REQ-002 SHALL take parameter CTRL_W, default 16, width of control bits that are zeroed on a bubble.
REQ-003 SHALL have port clk, input, 1, clock, rising edge.
REQ-004 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port flush, input, 1, synchronous squash of all held entries.
REQ-006 SHALL have port in_valid, input, 1, upstream entry present.
REQ-007 SHALL have port in_ready, output, 1, stage can accept an entry.
REQ-008 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-009 SHALL have port in_ctrl, input, CTRL_W, upstream control.
REQ-010 SHALL have port out_valid, output, 1, downstream entry present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts.
REQ-012 SHALL have port out_data, output, DATA_W, downstream payload.
REQ-013 SHALL have port out_ctrl, output, CTRL_W, downstream control.
REQ-014 SHALL have port stall_cnt, output, 32, stall-cycle count; present only under PIPE_STAGE_SKID_PERF_EN.

Function
REQ-015 SHALL hold two entries, main and skid, each with a valid bit; occupancy state is EMPTY (0), ONE (main only) or FULL (main+skid).
REQ-016 SHALL drive in_ready = !skid_valid from a register, with no combinational path from out_ready.
REQ-017 SHALL accept on in_valid && in_ready and present the entry on out_* the following cycle (latency 1).
REQ-018 SHALL complete a transfer on out_valid && out_ready.
REQ-019 EMPTY: on accept, go to ONE.
REQ-020 ONE: accept without transfer goes to FULL (the new entry goes to skid); transfer without accept goes to EMPTY; accept with transfer stays ONE (new entry replaces main).
REQ-021 FULL: on transfer, skid moves to main and state goes to ONE; in_ready is 0, so no accept.
REQ-022 SHALL preserve entry order; an entry is never dropped or duplicated absent flush.
REQ-023 SHALL output out_data = 0 and out_ctrl = 0 whenever out_valid = 0 (bubble semantics).
REQ-024 flush SHALL clear both valid bits, the data and the control registers at the next edge, giving state EMPTY.
REQ-025 flush SHALL take priority over a simultaneous accept; the incoming entry is discarded.
REQ-026 flush SHALL take priority over a simultaneous transfer; the transfer still counts as completed downstream in that cycle.
REQ-027 in_data and in_ctrl SHALL be ignored when in_valid = 0.

Reset
REQ-028 On reset, SHALL clear main, skid, valids and stall_cnt to 0, so out_valid = 0, out_* = 0 and in_ready = 1.
REQ-029 Reset asserted mid-transfer SHALL discard all entries; the first accept after deassertion lands in main.

Configuration
REQ-030 With PIPE_STAGE_SKID_PERF_EN defined, stall_cnt SHALL increment by 1 each cycle with out_valid && !out_ready, saturate at 0xFFFFFFFF, and be unaffected by flush.
REQ-031 Without PIPE_STAGE_SKID_PERF_EN, the stall_cnt port and counter logic SHALL be absent.

Structure
REQ-032 The shared package pipe_pkg SHALL hold the occupancy-state encoding and default DATA_W/CTRL_W constants.
REQ-033 The design SHALL use one sub-module, pipe_entry_reg: a valid+data+ctrl register with load and clear; it is instantiated twice (main, skid).

Verification
REQ-034 Stream: in_valid=1 with data 1..8 and out_ready=1 -> out_data 1..8 one cycle later, in_ready=1 throughout.
REQ-035 Backpressure: out_ready=0 while data 0xA, then 0xB is pushed -> FULL, in_ready=0; raising out_ready gives 0xA then 0xB in order.
REQ-036 Flush in FULL with in_valid=1, data 0xC -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and 0xC is never seen.
REQ-037 Reset asserted asynchronously in ONE -> out_valid=0 immediately, with no clock edge required.
REQ-038 PERF_EN: out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5; a following flush leaves stall_cnt=5.
REQ-039 Random in_valid/out_ready over 10k cycles -> scoreboard shows in-order, lossless delivery, with out_ctrl=0 whenever out_valid=0.
